uart_msg_rx: RTL and testbench

//  UART receiver and message parser: the receive end of the board's UART status link.

---
 rtl/uart_msg_rx.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_msg_rx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_rx.sv
// uart_msg_rx: oversampling 8N1 UART receiver with a "{<header>#<payload>#}" frame parser.
// A bit-level FSM recovers bytes from the synchronized rx line. A parser FSM consumes those
// bytes and reports the payload byte of each well-formed frame.
module uart_msg_rx #(
   parameter int         OVERSAMPLE = 16,
   parameter logic [7:0] START_CHAR = 8'h7B,
   parameter logic [7:0] DELIM_CHAR = 8'h23,
   parameter logic [7:0] END_CHAR   = 8'h7D,
   parameter int         MAX_LEN    = 32
) (
   input  logic       uart_clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_err,
   output logic [7:0] payload,
   output logic       payload_valid,
   output logic       msg_err,
   output logic       busy
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int LEN_W  = $clog2(MAX_LEN + 1);
   localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
   localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

   typedef enum logic [2:0] {
      B_IDLE,
      B_START,
      B_DATA,
      B_STOP,
      B_WAIT_HI
   } bit_state_t;

   typedef enum logic [2:0] {
      P_IDLE,
      P_HDR,
      P_VAL,
      P_DLM2,
      P_END
   } parse_state_t;

   // synchronizer and bit-level receiver
   logic              sync_1;
   logic              rx_s;
   bit_state_t        bit_state;
   logic [TICK_W-1:0] tick;
   logic [2:0]        bit_cnt;
   logic [7:0]        shift;

   // frame parser
   parse_state_t      p_state;
   logic [LEN_W-1:0]  len;
   logic [7:0]        cand;
   logic              byte_bad;
   logic              len_full;

   // Two-flop synchronizer; preset to idle-high so reset never looks like a start bit.
   always_ff @(posedge uart_clk or posedge rst) begin
      if (rst) begin
         sync_1 <= 1'b1;
         rx_s   <= 1'b1;
      end else begin
         sync_1 <= rx;
         rx_s   <= sync_1;
      end
   end

   // Bit FSM: detect start, sample each bit at its middle, check the stop bit.
   always_ff @(posedge uart_clk or posedge rst) begin
      if (rst) begin
         bit_state  <= B_IDLE;
         tick       <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         byte_data  <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (bit_state)
            B_IDLE: begin
               tick    <= '0;
               bit_cnt <= '0;
               if (!rx_s) begin
                  bit_state <= B_START;
               end
            end
            B_START: begin
               if (tick == HALF_TICK) begin
                  tick <= '0;
                  // a start bit that is gone by mid-bit was only a glitch
                  bit_state <= rx_s ? B_IDLE : B_DATA;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            B_DATA: begin
               if (tick == LAST_TICK) begin
                  tick  <= '0;
                  shift <= {rx_s, shift[7:1]};
                  if (bit_cnt == 3'd7) begin
                     bit_cnt   <= '0;
                     bit_state <= B_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            B_STOP: begin
               if (tick == LAST_TICK) begin
                  tick <= '0;
                  if (rx_s) begin
                     byte_data  <= shift;
                     byte_valid <= 1'b1;
                     bit_state  <= B_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     bit_state <= B_WAIT_HI;
                  end
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            B_WAIT_HI: begin
               // a held-low line (break) must not be mistaken for a new start bit
               if (rx_s) begin
                  bit_state <= B_IDLE;
               end
            end
            default: begin
               bit_state <= B_IDLE;
            end
         endcase
      end
   end

   assign busy = (bit_state != B_IDLE);

   // Byte mismatches in the two fixed-content positions after the payload.
   always_comb begin
      byte_bad = 1'b0;
      case (p_state)
         P_DLM2:  byte_bad = (byte_data != DELIM_CHAR);
         P_END:   byte_bad = (byte_data != END_CHAR);
         default: byte_bad = 1'b0;
      endcase
   end

   assign len_full = (len == LEN_MAX);

   // Parser FSM: walks each received byte through header, payload, delimiter and end.
   always_ff @(posedge uart_clk or posedge rst) begin
      if (rst) begin
         p_state       <= P_IDLE;
         len           <= '0;
         cand          <= '0;
         payload       <= '0;
         payload_valid <= 1'b0;
         msg_err       <= 1'b0;
      end else begin
         payload_valid <= 1'b0;
         msg_err       <= 1'b0;
         if (frame_err) begin
            // a corrupted byte aborts any frame in progress
            if (p_state != P_IDLE) begin
               msg_err <= 1'b1;
               p_state <= P_IDLE;
               len     <= '0;
            end
         end else if (byte_valid) begin
            if (p_state == P_IDLE) begin
               if (byte_data == START_CHAR) begin
                  p_state <= P_HDR;
                  len     <= LEN_ONE;
               end
            end else if (p_state == P_HDR && byte_data == START_CHAR) begin
               // a fresh '{' inside the header restarts the frame
               len <= LEN_ONE;
            end else if (len_full || byte_bad) begin
               msg_err <= 1'b1;
               if (byte_data == START_CHAR) begin
                  p_state <= P_HDR;
                  len     <= LEN_ONE;
               end else begin
                  p_state <= P_IDLE;
                  len     <= '0;
               end
            end else begin
               len <= len + 1'b1;
               case (p_state)
                  P_HDR: begin
                     if (byte_data == DELIM_CHAR) begin
                        p_state <= P_VAL;
                     end
                  end
                  P_VAL: begin
                     cand    <= byte_data;
                     p_state <= P_DLM2;
                  end
                  P_DLM2: begin
                     p_state <= P_END;
                  end
                  P_END: begin
                     payload       <= cand;
                     payload_valid <= 1'b1;
                     p_state       <= P_IDLE;
                     len           <= '0;
                  end
                  default: begin
                     p_state <= P_IDLE;
                     len     <= '0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_msg_rx.sv
// Testbench for uart_msg_rx: serial stimulus with random gaps and random frames,
// scored against a frame-buffer reference model of the receiver and parser.
module tb_uart_msg_rx;

   localparam int         OS    = 16;
   localparam logic [7:0] C_ST  = 8'h7B;
   localparam logic [7:0] C_DL  = 8'h23;
   localparam logic [7:0] C_EN  = 8'h7D;
   localparam int         MAXL  = 32;

   logic       uart_clk;
   logic       rst;
   logic       rx;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       frame_err;
   logic [7:0] payload;
   logic       payload_valid;
   logic       msg_err;
   logic       busy;

   int n_chk = 0;
   int n_err = 0;

   // observed events
   logic [7:0] obs_bytes[$];
   logic [7:0] obs_pay[$];
   int         obs_merr = 0;
   int         obs_ferr = 0;
   int         obs_ovl  = 0;

   // expected events from the model
   logic [7:0] exp_bytes[$];
   logic [7:0] exp_pay[$];
   int         exp_merr = 0;
   int         exp_ferr = 0;

   // reference model state: bytes of the open frame, position of the first '#'
   bit         m_in = 0;
   logic [7:0] m_buf[$];
   int         m_dpos = -1;
   logic [7:0] m_payload = 8'h00;

   uart_msg_rx dut (
      .uart_clk      (uart_clk),
      .rst           (rst),
      .rx            (rx),
      .byte_data     (byte_data),
      .byte_valid    (byte_valid),
      .frame_err     (frame_err),
      .payload       (payload),
      .payload_valid (payload_valid),
      .msg_err       (msg_err),
      .busy          (busy)
   );

   initial uart_clk = 1'b0;
   always #5 uart_clk = ~uart_clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // event monitor, sampled just after each active edge
   always @(posedge uart_clk) begin
      #1;
      if (byte_valid) obs_bytes.push_back(byte_data);
      if (payload_valid) obs_pay.push_back(payload);
      if (msg_err) obs_merr++;
      if (frame_err) obs_ferr++;
      if (byte_valid && (frame_err || payload_valid || msg_err)) obs_ovl++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_error(input logic [7:0] b);
      exp_merr++;
      if (b == C_ST) begin
         m_buf = {b};
         m_dpos = -1;
      end else begin
         m_in = 0;
      end
   endtask

   // model of one good byte arriving
   task automatic model_byte(input logic [7:0] b);
      int k;
      exp_bytes.push_back(b);
      if (!m_in) begin
         if (b == C_ST) begin
            m_in = 1;
            m_buf = {b};
            m_dpos = -1;
         end
         return;
      end
      if (m_dpos < 0 && b == C_ST) begin
         m_buf = {b};
         return;
      end
      if (m_buf.size() >= MAXL) begin
         model_error(b);
         return;
      end
      if (m_dpos < 0) begin
         if (b == C_DL) m_dpos = m_buf.size();
         m_buf.push_back(b);
         return;
      end
      k = m_buf.size() - m_dpos;
      if ((k == 2 && b != C_DL) || (k == 3 && b != C_EN)) begin
         model_error(b);
         return;
      end
      m_buf.push_back(b);
      if (k == 3) begin
         m_payload = m_buf[m_dpos + 1];
         exp_pay.push_back(m_payload);
         m_in = 0;
      end
   endtask

   task automatic model_ferr();
      exp_ferr++;
      if (m_in) begin
         exp_merr++;
         m_in = 0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      rx = 1'b0;
      repeat (OS) @(negedge uart_clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (OS) @(negedge uart_clk);
      end
      rx = stop_ok;
      repeat (OS) @(negedge uart_clk);
      if (stop_ok) begin
         model_byte(b);
         repeat ($urandom_range(0, 8)) @(negedge uart_clk);
      end else begin
         model_ferr();
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
   endtask

   task automatic compare_scn(input string name);
      int nb;
      int np;
      repeat (3 * OS) @(negedge uart_clk);
      check({name, " byte count"}, obs_bytes.size(), exp_bytes.size());
      nb = (obs_bytes.size() < exp_bytes.size()) ? obs_bytes.size() : exp_bytes.size();
      for (int i = 0; i < nb; i++)
         check({name, " byte_data"}, 32'(obs_bytes[i]), 32'(exp_bytes[i]));
      check({name, " payload_valid count"}, obs_pay.size(), exp_pay.size());
      np = (obs_pay.size() < exp_pay.size()) ? obs_pay.size() : exp_pay.size();
      for (int i = 0; i < np; i++)
         check({name, " payload value"}, 32'(obs_pay[i]), 32'(exp_pay[i]));
      check({name, " msg_err count"}, obs_merr, exp_merr);
      check({name, " frame_err count"}, obs_ferr, exp_ferr);
      check({name, " payload held"}, 32'(payload), 32'(m_payload));
      check({name, " busy idle"}, 32'(busy), 32'd0);
      check({name, " pulse overlap"}, obs_ovl, 0);
      $display("%s: bytes=%0d payloads=%0d msg_err=%0d frame_err=%0d payload=%02h",
               name, exp_bytes.size(), exp_pay.size(), exp_merr, exp_ferr, m_payload);
      obs_bytes.delete(); obs_pay.delete(); exp_bytes.delete(); exp_pay.delete();
      obs_merr = 0; obs_ferr = 0; obs_ovl = 0; exp_merr = 0; exp_ferr = 0;
   endtask

   task automatic check_all_zero(input string name);
      check({name, " byte_valid"}, 32'(byte_valid), 32'd0);
      check({name, " frame_err"}, 32'(frame_err), 32'd0);
      check({name, " byte_data"}, 32'(byte_data), 32'd0);
      check({name, " payload"}, 32'(payload), 32'd0);
      check({name, " payload_valid"}, 32'(payload_valid), 32'd0);
      check({name, " msg_err"}, 32'(msg_err), 32'd0);
      check({name, " busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      string fill;
      logic [7:0] pick[4];
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge uart_clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (4) @(negedge uart_clk);

      // 1: leading 0x00 fill, then a full status frame
      for (int i = 0; i < 16; i++) send_byte(8'h00, 1'b1);
      send_str("{bits_sent: #");
      send_byte(8'h2A, 1'b1);
      send_str("#}");
      compare_scn("fill+frame");

      // 2: payload equal to the delimiter
      send_str("{a:#");
      send_byte(8'h23, 1'b1);
      send_str("#}");
      compare_scn("delim payload");

      // 3: bad stop bit inside a frame, break, then a clean frame
      send_str("{h#");
      send_byte(8'h55, 1'b0);
      repeat (20 * OS) @(negedge uart_clk);
      rx = 1'b1;
      repeat (2 * OS) @(negedge uart_clk);
      send_str("{ok#");
      send_byte(8'h3C, 1'b1);
      send_str("#}");
      compare_scn("stop err");

      // 4: short low glitch
      rx = 1'b0;
      repeat (4) @(negedge uart_clk);
      check("glitch busy high", 32'(busy), 32'd1);
      rx = 1'b1;
      repeat (OS / 2 + 3) @(negedge uart_clk);
      check("glitch busy released", 32'(busy), 32'd0);
      compare_scn("glitch");

      // 5: missing end char, then a doubled delimiter with resync
      send_str("{x#");
      send_byte(8'h07, 1'b1);
      send_str("#X");
      compare_scn("no end");
      send_str("{x#");
      send_byte(8'h07, 1'b1);
      send_str("##{x#");
      send_byte(8'h09, 1'b1);
      send_str("#}");
      compare_scn("resync");

      // 6: reset in the middle of data bit 4, then an over-long frame, then a clean one
      send_str("{ab");
      rx = 1'b0;
      repeat (OS) @(negedge uart_clk);
      for (int i = 0; i < 4; i++) begin
         rx = i[0];
         repeat (OS) @(negedge uart_clk);
      end
      rx = 1'b0;
      repeat (OS / 2) @(negedge uart_clk);
      rst = 1'b1;
      rx  = 1'b1;
      #1;
      check_all_zero("mid-byte reset");
      repeat (3) @(negedge uart_clk);
      rst = 1'b0;
      m_in = 0;
      m_payload = 8'h00;
      repeat (2 * OS) @(negedge uart_clk);
      fill = "bits";
      send_byte(C_ST, 1'b1);
      for (int i = 0; i < 40; i++) send_byte(fill[i % 4], 1'b1);
      send_str("{z#");
      send_byte(8'h5C, 1'b1);
      send_str("#}");
      compare_scn("overflow");

      // 7: random well-formed frames separated by random fill
      for (int f = 0; f < 4; f++) begin
         repeat ($urandom_range(0, 3)) send_byte(8'($urandom_range(8'h61, 8'h7A)), 1'b1);
         send_byte(C_ST, 1'b1);
         repeat ($urandom_range(1, 5)) send_byte(8'($urandom_range(8'h41, 8'h5A)), 1'b1);
         send_byte(C_DL, 1'b1);
         send_byte(8'($urandom_range(0, 255)), 1'b1);
         send_str("#}");
      end
      compare_scn("random frames");

      // 8: random byte soup dominated by the framing characters
      pick[0] = C_ST; pick[1] = C_DL; pick[2] = C_EN; pick[3] = 8'h00;
      for (int i = 0; i < 30; i++) begin
         pick[3] = 8'($urandom_range(0, 255));
         send_byte(pick[$urandom_range(0, 3)], 1'b1);
      end
      compare_scn("random stream");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
